mem_responder: RTL and testbench

//  Tagged main-memory responder: the far end of the proc2mem/mem2proc bus that the dcache/icache controllers drive.

---
 rtl/mem_responder_pkg.sv | 27 ++
 rtl/mem_tag_freelist.sv | 49 ++++
 rtl/mem_responder.sv | 108 ++++++++++
 tb/tb_mem_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the memory responder and the cache controllers that drive it.
// NUM_MEM_TAGS and DATA_SIZE may be overridden by defining the macros ahead of this file.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif

package mem_responder_pkg;

  localparam int NUM_MEM_TAGS = `NUM_MEM_TAGS;
  localparam int DATA_SIZE    = `DATA_SIZE;
  localparam int STORE_ACK    = NUM_MEM_TAGS - 1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  // The highest tag of any tag space is reserved as the store acknowledge.
  function automatic int store_ack_tag(input int num_tags);
    return num_tags - 1;
  endfunction

endpackage

// File: rtl/mem_tag_freelist.sv
// Bitmap of free load tags (1..NUM_TAGS-2) with a lowest-free priority encoder.
// A same-cycle allocate and free of different tags are both applied.
module mem_tag_freelist
  import mem_responder_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS,
  parameter int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag
);

  localparam logic [NUM_TAGS-1:0] LOAD_TAGS = ({NUM_TAGS{1'b1}} >> 2) << 1;

  logic [NUM_TAGS-1:0] free_map;
  logic [NUM_TAGS-1:0] next_map;
  logic                any_free;

  // Scan downward so the last hit left standing is the lowest free tag.
  always_comb begin
    alloc_tag = '0;
    any_free  = 1'b0;
    for (int i = NUM_TAGS - 2; i >= 1; i--) begin
      if (free_map[i]) begin
        alloc_tag = TAG_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  assign alloc_grant = alloc_req & any_free;

  always_comb begin
    next_map = free_map;
    if (free_valid) next_map[free_tag] = 1'b1;
    if (alloc_grant) next_map[alloc_tag] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) free_map <= LOAD_TAGS;
    else       free_map <= next_map & LOAD_TAGS;
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged main-memory responder: stores acknowledged immediately, loads return after LOAD_LATENCY cycles.
// Define MEM_STALL_EN to refuse loads pseudo-randomly from an 8-bit LFSR and exercise retry paths.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter  int NUM_TAGS     = NUM_MEM_TAGS,
  parameter  int LOAD_LATENCY = 10,
  parameter  int MEM_DEPTH    = 8192,
  localparam int TAG_W        = $clog2(NUM_TAGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  BUS_COMMAND           proc2mem_command,
  input  logic [31:0]          proc2mem_addr,
  input  logic [DATA_SIZE-1:0] proc2mem_data,
  output logic [TAG_W-1:0]     mem2proc_response,
  output logic [DATA_SIZE-1:0] mem2proc_data,
  output logic [TAG_W-1:0]     mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [DATA_SIZE-1:0] data;
  } pipe_entry_t;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
  pipe_entry_t          pipe [LOAD_LATENCY];
  pipe_entry_t          new_entry;
  pipe_entry_t          out_entry;

  logic [IDX_W-1:0] mem_idx;
  logic             unused_addr_bits;
  logic             is_load;
  logic             is_store;
  logic             load_stall;
  logic             load_accept;
  logic [TAG_W-1:0] load_tag;

  assign mem_idx          = proc2mem_addr[IDX_W+2:3];
  assign unused_addr_bits = ^{proc2mem_addr[31:IDX_W+3], proc2mem_addr[2:0]};

  assign is_load  = !reset && (proc2mem_command == BUS_LOAD);
  assign is_store = !reset && (proc2mem_command == BUS_STORE);

`ifdef MEM_STALL_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; loads stall whenever its low two bits are zero.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load_stall = (lfsr[1:0] == 2'b00);
`else
  assign load_stall = 1'b0;
`endif

  mem_tag_freelist #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_freelist (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (is_load && !load_stall),
    .alloc_grant (load_accept),
    .alloc_tag   (load_tag),
    .free_valid  (out_entry.valid),
    .free_tag    (out_entry.tag)
  );

  always_comb begin
    mem2proc_response = '0;
    if (is_store)         mem2proc_response = TAG_W'(store_ack_tag(NUM_TAGS));
    else if (load_accept) mem2proc_response = load_tag;
  end

  // Load data is snapshotted at acceptance, so a younger store cannot alter it in flight.
  always_comb begin
    new_entry = '0;
    if (load_accept) begin
      new_entry.valid = 1'b1;
      new_entry.tag   = load_tag;
      new_entry.data  = mem[mem_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (is_store) mem[mem_idx] <= proc2mem_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LOAD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= new_entry;
      for (int i = 1; i < LOAD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_entry     = pipe[LOAD_LATENCY-1];
  assign mem2proc_tag  = out_entry.tag;
  assign mem2proc_data = out_entry.data;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized run against a
// transaction-level model (tag pool, completion queue, memory image).
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NT   = 8;
  localparam int LAT  = 10;
  localparam int TW   = $clog2(NT);
  localparam int NT2  = NUM_MEM_TAGS;
  localparam int TW2  = $clog2(NT2);

  logic clock = 1'b0;
  logic reset = 1'b1;

  BUS_COMMAND           cmd;
  logic [31:0]          addr;
  logic [DATA_SIZE-1:0] wdata;
  logic [TW-1:0]        resp;
  logic [DATA_SIZE-1:0] rdata;
  logic [TW-1:0]        tag;

  BUS_COMMAND           cmd2;
  logic [31:0]          addr2;
  logic [DATA_SIZE-1:0] wdata2;
  logic [TW2-1:0]       resp2;
  logic [DATA_SIZE-1:0] rdata2;
  logic [TW2-1:0]       tag2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_responder #(.NUM_TAGS(NT), .LOAD_LATENCY(LAT), .MEM_DEPTH(8192)) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_addr     (addr),
    .proc2mem_data     (wdata),
    .mem2proc_response (resp),
    .mem2proc_data     (rdata),
    .mem2proc_tag      (tag)
  );

  mem_responder #(.LOAD_LATENCY(1)) dut_l1 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd2),
    .proc2mem_addr     (addr2),
    .proc2mem_data     (wdata2),
    .mem2proc_response (resp2),
    .mem2proc_data     (rdata2),
    .mem2proc_tag      (tag2)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input BUS_COMMAND c, input logic [31:0] a, input logic [DATA_SIZE-1:0] d);
    cmd   = c;
    addr  = a;
    wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(BUS_NONE, 32'h0, '0);
    cmd2 = BUS_NONE;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(BUS_LOAD, 32'h100, '0);
    cmd2 = BUS_LOAD;
    next_cycle();
    @(negedge clock);
    total++; if (resp !== '0) begin bad++; $display("[TB] FAIL reset_resp: got %0d expected 0", resp); end
    total++; if (tag !== '0) begin bad++; $display("[TB] FAIL reset_tag: got %0d expected 0", tag); end
    total++; if (rdata !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h expected 0", rdata); end
    total++; if (resp2 !== '0) begin bad++; $display("[TB] FAIL reset_resp_l1: got %0d expected 0", resp2); end
    total++; if (tag2 !== '0) begin bad++; $display("[TB] FAIL reset_tag_l1: got %0d expected 0", tag2); end
    next_cycle();
    reset = 1'b0;
    drive(BUS_NONE, 32'h0, '0);
    cmd2 = BUS_NONE;
  endtask

  task automatic test_store_load();
    do_reset();
    drive(BUS_STORE, 32'h100, 64'hDEAD_BEEF_0123_4567);
    @(negedge clock);
    total++; if (resp !== TW'(7)) begin bad++; $display("[TB] FAIL store_ack: got %0d expected 7", resp); end
    next_cycle();
    drive(BUS_LOAD, 32'h104, '0);
    @(negedge clock);
    total++; if (resp !== TW'(1)) begin bad++; $display("[TB] FAIL load_resp: got %0d expected 1", resp); end
    next_cycle();
    drive(BUS_NONE, 32'h0, '0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      total++;
      if (tag !== TW'((k == LAT) ? 1 : 0)) begin
        bad++; $display("[TB] FAIL t1_tag cycle+%0d: got %0d expected %0d", k, tag, (k == LAT) ? 1 : 0);
      end
      if (k == LAT) begin
        total++;
        if (rdata !== 64'hDEAD_BEEF_0123_4567) begin
          bad++; $display("[TB] FAIL t1_data: got %h expected deadbeef01234567", rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int exp_resp [12];
    exp_resp = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 1};
    do_reset();
    drive(BUS_LOAD, 32'h100, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      total++;
      if (resp !== TW'(exp_resp[i])) begin
        bad++; $display("[TB] FAIL b2b_resp[%0d]: got %0d expected %0d", i, resp, exp_resp[i]);
      end
      total++;
      if (tag !== TW'((i >= LAT) ? i - LAT + 1 : 0)) begin
        bad++; $display("[TB] FAIL b2b_tag[%0d]: got %0d expected %0d", i, tag, (i >= LAT) ? i - LAT + 1 : 0);
      end
      next_cycle();
    end
    drive(BUS_NONE, 32'h0, '0);
  endtask

  task automatic test_store_after_load();
    logic [63:0] old_val;
    logic [63:0] new_val;
    old_val = {$urandom, $urandom};
    new_val = ~old_val;
    do_reset();
    drive(BUS_STORE, 32'h200, old_val);
    next_cycle();
    drive(BUS_LOAD, 32'h200, '0);
    @(negedge clock);
    total++; if (resp !== TW'(1)) begin bad++; $display("[TB] FAIL sal_load_resp: got %0d expected 1", resp); end
    next_cycle();
    drive(BUS_STORE, 32'h200, new_val);
    @(negedge clock);
    total++; if (resp !== TW'(7)) begin bad++; $display("[TB] FAIL sal_store_resp: got %0d expected 7", resp); end
    next_cycle();
    drive(BUS_NONE, 32'h0, '0);
    repeat (LAT - 2) next_cycle();
    @(negedge clock);
    total++; if (tag !== TW'(1)) begin bad++; $display("[TB] FAIL sal_tag: got %0d expected 1", tag); end
    total++; if (rdata !== old_val) begin bad++; $display("[TB] FAIL sal_old_data: got %h expected %h", rdata, old_val); end
    next_cycle();
    drive(BUS_LOAD, 32'h200, '0);
    @(negedge clock);
    total++; if (resp !== TW'(1)) begin bad++; $display("[TB] FAIL sal_reload_resp: got %0d expected 1", resp); end
    next_cycle();
    drive(BUS_NONE, 32'h0, '0);
    repeat (LAT - 1) next_cycle();
    @(negedge clock);
    total++; if (tag !== TW'(1)) begin bad++; $display("[TB] FAIL sal_reload_tag: got %0d expected 1", tag); end
    total++; if (rdata !== new_val) begin bad++; $display("[TB] FAIL sal_new_data: got %h expected %h", rdata, new_val); end
    next_cycle();
  endtask

  task automatic test_reset_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(BUS_LOAD, 32'h100, '0);
      @(negedge clock);
      total++;
      if (resp !== TW'(i + 1)) begin bad++; $display("[TB] FAIL flush_resp[%0d]: got %0d expected %0d", i, resp, i + 1); end
      next_cycle();
    end
    drive(BUS_NONE, 32'h0, '0);
    repeat (3) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      total++;
      if (tag !== '0) begin bad++; $display("[TB] FAIL flush_tag[%0d]: got %0d expected 0", k, tag); end
      next_cycle();
    end
    drive(BUS_LOAD, 32'h100, '0);
    @(negedge clock);
    total++; if (resp !== TW'(1)) begin bad++; $display("[TB] FAIL flush_next_resp: got %0d expected 1", resp); end
    next_cycle();
    drive(BUS_NONE, 32'h0, '0);
  endtask

  task automatic test_latency1();
    logic [63:0] d;
    logic [63:0] prev;
    prev = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      cmd2 = BUS_STORE; addr2 = 32'h300 + 32'(i * 8); wdata2 = d;
      @(negedge clock);
      total++;
      if (resp2 !== TW2'(NT2 - 1)) begin bad++; $display("[TB] FAIL l1_store_resp[%0d]: got %0d expected %0d", i, resp2, NT2 - 1); end
      if (i > 0) begin
        total++; if (tag2 !== TW2'(1)) begin bad++; $display("[TB] FAIL l1_tag[%0d]: got %0d expected 1", i, tag2); end
        total++; if (rdata2 !== prev) begin bad++; $display("[TB] FAIL l1_data[%0d]: got %h expected %h", i, rdata2, prev); end
      end
      next_cycle();
      cmd2 = BUS_LOAD;
      @(negedge clock);
      total++;
      if (resp2 !== TW2'(1)) begin bad++; $display("[TB] FAIL l1_load_resp[%0d]: got %0d expected 1", i, resp2); end
      next_cycle();
      prev = d;
    end
    cmd2 = BUS_NONE;
    @(negedge clock);
    total++; if (tag2 !== TW2'(1)) begin bad++; $display("[TB] FAIL l1_last_tag: got %0d expected 1", tag2); end
    total++; if (rdata2 !== prev) begin bad++; $display("[TB] FAIL l1_last_data: got %h expected %h", rdata2, prev); end
    next_cycle();
  endtask

  typedef struct {
    int          due;
    logic [TW-1:0] tag;
    logic [63:0] data;
  } pend_t;

  task automatic test_random();
    logic [63:0]   mem_m [int];
    bit            free_m [NT];
    pend_t         pq [$];
    pend_t         p;
    logic [7:0]    lfsr_m;
    bit            stall_mode;
    bit            holding;
    logic [31:0]   held_addr;
    BUS_COMMAND    c;
    logic [31:0]   a;
    logic [63:0]   d;
    int            idx;
    int            r;
    int            exp_tag;
    logic [63:0]   exp_data;
    int            exp_resp;
    int            lowest;
    bit            accept;
`ifdef MEM_STALL_EN
    stall_mode = 1'b1;
`else
    stall_mode = 1'b0;
`endif
    do_reset();
    for (int t = 0; t < NT; t++) free_m[t] = (t >= 1 && t <= NT - 2);
    lfsr_m  = 8'hA5;
    holding = 1'b0;
    held_addr = '0;
    for (int cyc = 0; cyc < 232; cyc++) begin
      d = {$urandom, $urandom};
      if (cyc < 16) begin
        c = BUS_STORE;
        a = ($urandom & 32'hFFFF_0000) | 32'(cyc << 3) | ($urandom & 32'h7);
      end else if (cyc >= 216) begin
        c = BUS_NONE;
        a = $urandom;
      end else if (holding) begin
        c = BUS_LOAD;
        a = held_addr;
      end else begin
        r = $urandom_range(0, 9);
        a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 15) << 3) | ($urandom & 32'h7);
        if (r < 2)       c = BUS_NONE;
        else if (r < 4)  c = BUS_STORE;
        else if (r == 4) c = BUS_COMMAND'(2'b11);
        else             c = BUS_LOAD;
      end
      idx = int'((a >> 3) % 8192);

      exp_tag  = 0;
      exp_data = '0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        exp_tag  = int'(pq[0].tag);
        exp_data = pq[0].data;
      end
      lowest = 0;
      for (int t = NT - 2; t >= 1; t--) if (free_m[t]) lowest = t;
      accept   = (c == BUS_LOAD) && (lowest != 0) && !(stall_mode && lfsr_m[1:0] == 2'b00);
      exp_resp = (c == BUS_STORE) ? NT - 1 : (accept ? lowest : 0);

      drive(c, a, d);
      @(negedge clock);
      total++;
      if (resp !== TW'(exp_resp)) begin bad++; $display("[TB] FAIL rnd_resp cyc=%0d: got %0d expected %0d", cyc, resp, exp_resp); end
      total++;
      if (tag !== TW'(exp_tag)) begin bad++; $display("[TB] FAIL rnd_tag cyc=%0d: got %0d expected %0d", cyc, tag, exp_tag); end
      if (exp_tag != 0) begin
        total++;
        if (rdata !== exp_data) begin bad++; $display("[TB] FAIL rnd_data cyc=%0d: got %h expected %h", cyc, rdata, exp_data); end
      end

      if (c == BUS_STORE) mem_m[idx] = d;
      if (accept) begin
        free_m[lowest] = 1'b0;
        p.due  = cyc + LAT;
        p.tag  = TW'(lowest);
        p.data = mem_m.exists(idx) ? mem_m[idx] : 64'h0;
        pq.push_back(p);
      end
      if (exp_tag != 0) begin
        free_m[exp_tag] = 1'b1;
        void'(pq.pop_front());
      end
      holding   = (c == BUS_LOAD) && !accept;
      held_addr = a;
      lfsr_m    = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      next_cycle();
    end
    drive(BUS_NONE, 32'h0, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive(BUS_NONE, 32'h0, '0);
    cmd2   = BUS_NONE;
    addr2  = '0;
    wdata2 = '0;
    test_reset();
`ifndef MEM_STALL_EN
    test_store_load();
    test_back_to_back();
    test_store_after_load();
    test_reset_flush();
    test_latency1();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
